// File: rtl/sys_skew_feeder_if.sv
// Load port of the skew feeder: byte-wide (N-bit) vector writes into the
// A or B operand bank with a valid/ready handshake.
//   load_valid : master requests a write
//   load_sel   : target bank, 0 = A, 1 = B
//   load_data  : vector to store
//   load_ready : slave accepts the write this cycle when high
interface sys_skew_feeder_if #(
  parameter int N = 8
);
  logic         load_valid;
  logic         load_sel;
  logic [N-1:0] load_data;
  logic         load_ready;

  modport master (output load_valid, load_sel, load_data, input load_ready);
  modport slave  (input load_valid, load_sel, load_data, output load_ready);
endinterface

// File: rtl/sys_skew_feeder.sv
// Operand sequencer for an N x N bit systolic array. Buffers N A-vectors and
// N B-vectors, streams them lane-skewed so cell (i,j) sees a_k[j] and b_k[i]
// together at t = k+i+j, then runs the array readout and strobes each row.
//   clk, reset     : clock, synchronous active-high reset
//   ld             : load port (slave side of sys_skew_feeder_if)
//   start_i        : begin a run (honoured in IDLE only)
//   start_err_o    : 1-cycle pulse, start in IDLE with a bank not full
//   sys_in1_o/2_o  : A / B lanes to the array
//   sys_in_valid_o : array input valid
//   readout_o      : array readout phase
//   rd_strobe_o    : consumer samples the array output this cycle
//   rd_row_o       : emission index of the strobed row
//   busy_o         : run in progress
//   done_o         : 1-cycle pulse at end of run
module sys_skew_feeder #(
  parameter int N  = 8,
  parameter int CW = $clog2(3*N),
  parameter int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  sys_skew_feeder_if.slave ld,
  input  logic          start_i,
  output logic          start_err_o,
  output logic [N-1:0]  sys_in1_o,
  output logic [N-1:0]  sys_in2_o,
  output logic          sys_in_valid_o,
  output logic          readout_o,
  output logic          rd_strobe_o,
  output logic [RW-1:0] rd_row_o,
  output logic          busy_o,
  output logic          done_o
);
  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_READOUT, S_DONE} state_t;

  localparam int              CNTW     = $clog2(N+1);
  localparam logic [CW-1:0]   T_LAST   = CW'(3*N-3);
  localparam logic [CW-1:0]   T_DRAIN  = CW'(2*N-1);
  localparam logic [CW-1:0]   R_LAST   = CW'(N);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(N);

  state_t          state_q, state_d;
  logic [CW-1:0]   t_q, t_d;
  logic [CNTW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [N-1:0]    a_mem [N];
  logic [N-1:0]    b_mem [N];
  logic            a_we, b_we, start_bad;
  logic [N-1:0]    in1_d, in2_d;
  logic [N-1:0]    a_word, b_word;
  logic [RW-1:0]   row_d;

  assign ld.load_ready = (state_q == S_IDLE) &&
                         (ld.load_sel ? (b_cnt_q < CNT_FULL) : (a_cnt_q < CNT_FULL));
  assign a_we = ld.load_valid && ld.load_ready && !ld.load_sel;
  assign b_we = ld.load_valid && ld.load_ready &&  ld.load_sel;

  always_comb begin
    a_cnt_d   = a_cnt_q + CNTW'(a_we);
    b_cnt_d   = b_cnt_q + CNTW'(b_we);
    state_d   = state_q;
    t_d       = t_q;
    start_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start arriving with the last load is judged on the updated counts.
        if (start_i) begin
          if (a_cnt_d == CNT_FULL && b_cnt_d == CNT_FULL) begin
            state_d = S_STREAM;
            t_d     = '0;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_STREAM, S_DRAIN: begin
        if (t_q == T_LAST) begin
          state_d = S_READOUT;
          t_d     = '0;
        end else begin
          t_d     = t_q + CW'(1);
          state_d = (t_d >= T_DRAIN) ? S_DRAIN : S_STREAM;
        end
      end
      S_READOUT: begin
        if (t_q == R_LAST) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        a_cnt_d = '0;
        b_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Skewed lanes for the cycle about to start. Lane j carries vector k when
  // t == k+j. A bank word written on this same edge is bypassed so the lanes
  // never see the stale entry (only reachable when N == 1).
  always_comb begin
    in1_d  = '0;
    in2_d  = '0;
    a_word = '0;
    b_word = '0;
    if (state_d == S_STREAM) begin
      for (int k = 0; k < N; k++) begin
        a_word = (a_we && a_cnt_q == CNTW'(k)) ? ld.load_data : a_mem[k];
        b_word = (b_we && b_cnt_q == CNTW'(k)) ? ld.load_data : b_mem[k];
        for (int j = 0; j < N; j++) begin
          if (int'(t_d) == k + j) begin
            in1_d[j] = a_word[j];
            in2_d[j] = b_word[j];
          end
        end
      end
    end
  end

  // Readout step r = t_d; r == 0 only flushes the array's stale last row.
  always_comb begin
    row_d = '0;
    if (state_d == S_READOUT && t_d != '0) row_d = RW'(t_d - CW'(1));
  end

  // Control and registered array-facing outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      t_q            <= '0;
      a_cnt_q        <= '0;
      b_cnt_q        <= '0;
      start_err_o    <= 1'b0;
      sys_in1_o      <= '0;
      sys_in2_o      <= '0;
      sys_in_valid_o <= 1'b0;
      readout_o      <= 1'b0;
      rd_strobe_o    <= 1'b0;
      rd_row_o       <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      a_cnt_q        <= a_cnt_d;
      b_cnt_q        <= b_cnt_d;
      start_err_o    <= start_bad;
      sys_in1_o      <= in1_d;
      sys_in2_o      <= in2_d;
      sys_in_valid_o <= (state_d == S_STREAM) || (state_d == S_DRAIN);
      readout_o      <= (state_d == S_READOUT);
      rd_strobe_o    <= (state_d == S_READOUT) && (t_d != '0);
      rd_row_o       <= row_d;
      busy_o         <= (state_d != S_IDLE);
      done_o         <= (state_d == S_DONE);
    end
  end

  // Operand banks
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (a_we && a_cnt_q == CNTW'(k)) a_mem[k] <= ld.load_data;
      if (b_we && b_cnt_q == CNTW'(k)) b_mem[k] <= ld.load_data;
    end
  end
endmodule

// File: tb/tb_sys_skew_feeder.sv
module tb_sys_skew_feeder;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start_err;
  logic [7:0] sys_in1, sys_in2;
  logic       sys_in_valid, readout, rd_strobe, busy, done;
  logic [2:0] rd_row;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] exp_a [N];
  logic [7:0] exp_b [N];
  logic [7:0] in1_t0, in1_t7, in1_t14, in2_t0, in2_t7, in2_t14;
  int         nval, nstr, done_c;

  sys_skew_feeder_if #(.N(N)) ld_if ();

  sys_skew_feeder #(.N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .ld             (ld_if),
    .start_i        (start),
    .start_err_o    (start_err),
    .sys_in1_o      (sys_in1),
    .sys_in2_o      (sys_in2),
    .sys_in_valid_o (sys_in_valid),
    .readout_o      (readout),
    .rd_strobe_o    (rd_strobe),
    .rd_row_o       (rd_row),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {7'd0, start_err, busy, done, sys_in_valid, readout, rd_strobe, rd_row, sys_in1, sys_in2};
  endfunction

  // Cycle c = 1 is the first cycle after the start-accept edge (t = 0).
  function automatic logic [31:0] exp_vec(input int c);
    logic [7:0] e1, e2;
    logic       v, ro, st, dn, bz;
    logic [2:0] row;
    int         t;
    e1 = '0; e2 = '0;
    t  = c - 1;
    if (c <= 22) begin
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++)
          if (t == k + j) begin
            e1[j] = exp_a[k][j];
            e2[j] = exp_b[k][j];
          end
    end
    v   = (c <= 22);
    ro  = (c >= 23 && c <= 31);
    st  = (c >= 24 && c <= 31);
    row = st ? 3'(c - 24) : 3'd0;
    dn  = (c == 32);
    bz  = (c <= 32);
    return {7'd0, 1'b0, bz, dn, v, ro, st, row, e1, e2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [7:0] data);
    ld_if.load_valid = 1'b1;
    ld_if.load_sel   = sel;
    ld_if.load_data  = data;
    step();
    ld_if.load_valid = 1'b0;
  endtask

  task automatic load_banks();
    for (int k = 0; k < N; k++) load(1'b0, exp_a[k]);
    for (int k = 0; k < N; k++) load(1'b1, exp_b[k]);
  endtask

  task automatic check_ready(input string tag, input logic sel, input logic exp);
    ld_if.load_sel = sel;
    #1;
    chk(tag, {31'd0, ld_if.load_ready}, {31'd0, exp});
  endtask

  // Accept a start and follow the whole run cycle by cycle; a stray start
  // mid-run must not raise start_err.
  task automatic run_and_check(input string tag);
    nval = 0; nstr = 0; done_c = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      chk(tag, obs_vec(), exp_vec(c));
      if (sys_in_valid) nval++;
      if (rd_strobe) nstr++;
      if (done && done_c == 0) done_c = c;
      if (c == 1)  begin in1_t0  = sys_in1; in2_t0  = sys_in2; end
      if (c == 8)  begin in1_t7  = sys_in1; in2_t7  = sys_in2; end
      if (c == 15) begin in1_t14 = sys_in1; in2_t14 = sys_in2; end
      start = (c == 10);
      step();
    end
    start = 1'b0;
    chk({tag, "_nvalid"}, nval, 22);
    chk({tag, "_nstrobe"}, nstr, 8);
    chk({tag, "_done_cycle"}, done_c, 32);
    check_ready({tag, "_ready_a_after"}, 1'b0, 1'b1);
    check_ready({tag, "_ready_b_after"}, 1'b1, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    ld_if.load_valid = 1'b0; ld_if.load_sel = 1'b0; ld_if.load_data = '0;
    step(); step();
    reset = 1'b0;
    chk("reset_outputs", obs_vec(), 32'd0);
    check_ready("reset_ready_a", 1'b0, 1'b1);
    check_ready("reset_ready_b", 1'b1, 1'b1);

    // Start with B one short
    for (int k = 0; k < N; k++) begin exp_a[k] = 8'hFF; exp_b[k] = 8'hFF; end
    for (int k = 0; k < N; k++) load(1'b0, 8'hFF);
    check_ready("a_full_ready", 1'b0, 1'b0);
    for (int k = 0; k < N-1; k++) load(1'b1, 8'hFF);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_err_pulse", {31'd0, start_err}, 32'd1);
    chk("start_err_busy", {31'd0, busy}, 32'd0);
    step();
    chk("start_err_clear", {31'd0, start_err}, 32'd0);
    chk("start_err_idle", {31'd0, busy}, 32'd0);
    check_ready("b_last_ready", 1'b1, 1'b1);
    load(1'b1, 8'hFF);
    ld_if.load_valid = 1'b1; ld_if.load_sel = 1'b1; ld_if.load_data = 8'h00;
    #1;
    chk("b_full_ready", {31'd0, ld_if.load_ready}, 32'd0);
    step();
    ld_if.load_valid = 1'b0;

    // All-ones run; the dropped 9th B write must not disturb anything
    run_and_check("ff_run");
    chk("ff_t0_in1", in1_t0, 8'h01);   chk("ff_t0_in2", in2_t0, 8'h01);
    chk("ff_t7_in1", in1_t7, 8'hFF);   chk("ff_t7_in2", in2_t7, 8'hFF);
    chk("ff_t14_in1", in1_t14, 8'h80); chk("ff_t14_in2", in2_t14, 8'h80);

    // Single product: only A[0] and B[0] carry a one
    for (int k = 0; k < N; k++) begin exp_a[k] = 8'h00; exp_b[k] = 8'h00; end
    exp_a[0] = 8'h01; exp_b[0] = 8'h01;
    load_banks();
    run_and_check("one_run");
    chk("one_t0_in1", in1_t0, 8'h01);
    chk("one_t7_in1", in1_t7, 8'h00);

    // Mixed patterns, loaded straight after done, run twice back to back
    for (int k = 0; k < N; k++) begin
      exp_a[k] = 8'(8'hA5 ^ (k * 8'h13));
      exp_b[k] = 8'(8'h3C + (k * 8'h29));
    end
    load_banks();
    run_and_check("mix_run1");
    load_banks();
    run_and_check("mix_run2");

    // Reset in the middle of streaming (t = 5)
    for (int k = 0; k < N; k++) begin exp_a[k] = 8'hFF; exp_b[k] = 8'hFF; end
    load_banks();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("mid_t5_in1", sys_in1, 8'h3F);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_reset_outputs", obs_vec(), 32'd0);
    check_ready("mid_reset_ready_a", 1'b0, 1'b1);
    check_ready("mid_reset_ready_b", 1'b1, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_reset_start_err", {31'd0, start_err}, 32'd1);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    step();
    chk("mid_reset_err_clear", {31'd0, start_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
